// File: rtl/muldiv16_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : muldiv16_issue (with mul16 / div16 iterative engines)            |
// | Purpose : Issues one 16-bit mul/div to the shift engines, counts the fixed |
// |           engine latency and holds the result on a valid/ready port.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+

// Shift-add multiplier; start (reset) loads operands, 16 steps yield a*b mod 2^16.
module mul16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result
);

  logic [15:0] r_mcand;
  logic [15:0] r_mplier;
  logic [15:0] r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= a;
      r_mplier <= b;
      r_acc    <= 16'h0000;
    end else begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign result = r_acc;

endmodule

// Restoring divider; start (reset) loads operands, 16 steps yield floor(a/b).
// A zero divisor makes every trial subtraction succeed, giving 0xFFFF.
module div16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result
);

  logic [15:0] r_quo;
  logic [15:0] r_rem;
  logic [15:0] r_div;
  logic [16:0] w_shift;
  logic        w_ge;

  assign w_shift = {r_rem, r_quo[15]};
  assign w_ge    = (w_shift >= {1'b0, r_div});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_quo <= a;
      r_rem <= 16'h0000;
      r_div <= b;
    end else begin
      r_rem <= w_ge ? 16'(w_shift - {1'b0, r_div}) : w_shift[15:0];
      r_quo <= {r_quo[14:0], w_ge};
    end
  end

  assign result = r_quo;

endmodule

module muldiv16_issue #(
  parameter int LATENCY = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_op,
  output logic        rsp_div0,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_CAPT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] c_cnt_last = 4'(LATENCY - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_rsp_data;
  logic        r_rsp_op;
  logic        r_rsp_div0;

  logic        w_accept;
  logic        w_eng_start;
  logic        w_in_idle;
  logic        w_in_done;
  logic [15:0] w_mul_p;
  logic [15:0] w_div_q;

  // Next state and decoded state flags
  always_comb begin
    w_state_nxt = r_state;
    w_in_idle   = 1'b0;
    w_in_done   = 1'b0;
    w_eng_start = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_in_idle = 1'b1;
        if (req_valid && reset_n) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_eng_start = 1'b0;
        if (r_cnt == c_cnt_last) begin
          w_state_nxt = S_CAPT;
        end
      end
      S_CAPT: begin
        w_eng_start = 1'b0;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_in_done = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Engines stay parked while the controller itself is held in reset
    if (!reset_n) begin
      w_eng_start = 1'b1;
    end
  end

  assign req_ready = w_in_idle & reset_n;
  assign w_accept  = req_valid & req_ready;
  assign rsp_valid = w_in_done;
  assign busy      = ~w_in_idle;
  assign rsp_data  = r_rsp_data;
  assign rsp_op    = r_rsp_op;
  assign rsp_div0  = r_rsp_div0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 4'd0;
    end else if (r_state == S_LOAD) begin
      r_cnt <= 4'd0;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op <= 1'b0;
      r_a  <= 16'h0000;
      r_b  <= 16'h0000;
    end else if (w_accept) begin
      r_op <= req_op;
      r_a  <= req_a;
      r_b  <= req_b;
    end
  end

  // Sampled on the CAPT edge: the engines hold exactly LATENCY steps of work
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_data <= 16'h0000;
      r_rsp_op   <= 1'b0;
      r_rsp_div0 <= 1'b0;
    end else if (r_state == S_CAPT) begin
      r_rsp_data <= r_op ? w_div_q : w_mul_p;
      r_rsp_op   <= r_op;
      r_rsp_div0 <= r_op & (r_b == 16'h0000);
    end
  end

  mul16 u_mul16 (
    .clk    (clk),
    .reset  (w_eng_start),
    .a      (r_a),
    .b      (r_b),
    .result (w_mul_p)
  );

  div16 u_div16 (
    .clk    (clk),
    .reset  (w_eng_start),
    .a      (r_a),
    .b      (r_b),
    .result (w_div_q)
  );

endmodule
`default_nettype wire
